exp5_unidade_controle_jogada: RTL and testbench
===============================================

// Module: exp5_unidade_controle_jogada
// PURPOSE
//  Moore FSM that sequences the play datapath of the memory game: address counter,
//  play register and comparator. Each round waits for a player press with a timeout,
//  registers the play, compares it and advances the counter. Ends in win, loss or
//  timeout. Sits beside the datapath in the top-level game module and replaces the
//  free-running control unit.
// PARAMETERS
//  TIMEOUT  5000  cycles allowed in ESPERA per play (>=2); timer width TW=$clog2(TIMEOUT)
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high; forces INICIAL
//  iniciar    in   1   start/restart request (level)
//  jogada     in   1   level: any play button pressed (OR of buttons)
//  fimC       in   1   datapath counter at last address
//  igual      in   1   comparator: registered play == memory data
//  zeraC      out  1   clear address counter
//  contaC     out  1   increment address counter
//  zeraR      out  1   clear play register
//  registraR  out  1   load play register
//  pronto     out  1   game finished (any terminal state)
//  ganhou     out  1   terminal: all plays correct
//  perdeu     out  1   terminal: wrong play
//  timeout    out  1   terminal: no play within TIMEOUT cycles
//  db_estado  out  4   current state code (debug)
// BEHAVIOUR
//  State codes: INICIAL=0, PREPARA=1, ESPERA=2, REGISTRA=4, COMPARA=5, PROXIMO=6,
//    FIM_ACERTO=A, FIM_TIMEOUT=B, FIM_ERRO=E. Unused codes go to INICIAL; db_estado=F.
//  Transitions:
//    INICIAL -> PREPARA if iniciar, else stay.  PREPARA -> ESPERA.
//    ESPERA  -> REGISTRA if press; else -> FIM_TIMEOUT if timer==TIMEOUT-1; else stay.
//    REGISTRA -> COMPARA.
//    COMPARA -> FIM_ERRO if !igual; else FIM_ACERTO if fimC; else PROXIMO.
//    PROXIMO -> ESPERA.  Terminal states -> PREPARA if iniciar, else stay.
//  Press detect: jogada_q <= jogada each cycle (reset 0). press = jogada & ~jogada_q.
//    Press counts only in ESPERA; pulses elsewhere are dropped. A held button gives one
//    press; a new press needs a release first.
//  Timer (TW bits): 0 on reset and in every state except ESPERA. +1 per ESPERA cycle.
//    ESPERA lasts at most TIMEOUT cycles. Press wins over timeout in the same cycle.
//  Outputs, all Moore, decoded from state only:
//    zeraC=zeraR=1 in INICIAL,PREPARA; registraR=1 in REGISTRA; contaC=1 in PROXIMO;
//    pronto=1 in A,B,E; ganhou=1 in A; timeout=1 in B; perdeu=1 in E.
//  Reset values: state INICIAL, timer 0, jogada_q 0. Outputs zeraC=zeraR=1, others 0,
//    db_estado=0.
//  Latency: press seen at edge n -> REGISTRA in cycle n+1 -> COMPARA n+2 -> PROXIMO or
//    terminal n+3 -> ESPERA n+4.
//  Reset mid-game: immediate return to INICIAL; the in-flight play is discarded.
//  Terminal states hold until iniciar; iniciar ignored in all non-idle, non-terminal states.
// TESTING (TIMEOUT=8 in bench)
//  Win: iniciar; 4 correct presses (igual=1), fimC=1 on 4th -> states 1,2,4,5,6..,A; ganhou=pronto=1; contaC 3 pulses.
//  Loss: igual=0 at 2nd press -> COMPARA->E; perdeu=pronto=1, ganhou=0; 1 contaC pulse total.
//  Timeout: no press after PREPARA -> exactly 8 cycles in ESPERA, then B; timeout=pronto=1.
//  Boundary: press rises in 8th ESPERA cycle (timer=7) -> REGISTRA, not B.
//  Held button: jogada high 20 cycles across PROXIMO -> one registraR only; next ESPERA times out.
//  Async reset in COMPARA mid-clock -> db_estado=0, zeraC=1 before next edge; restart via iniciar works.

Source files
------------

// File: rtl/exp5_unidade_controle_jogada.sv
// Play-sequencing control unit for the memory game: waits for a press
// (with timeout), registers and compares it, steps the address counter.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   iniciar               start / restart request (level)
//   jogada                any play button held (level)
//   fimC, igual           counter at last address, play matches memory
//   zeraC, contaC         clear / increment address counter
//   zeraR, registraR      clear / load play register
//   pronto                game over (win, loss or timeout)
//   ganhou, perdeu        game won / lost
//   timeout               no play within TIMEOUT cycles
//   db_estado             current state code, F for unused codes
module exp5_unidade_controle_jogada #(
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       fimC,
  input  logic       igual,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hB,
    FIM_ERRO    = 4'hE
  } estado_t;

  estado_t       state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          jogada_q;
  logic          press;
  logic          tmo_hit;

  logic       zeraC_d, contaC_d, zeraR_d, registraR_d;
  logic       pronto_d, ganhou_d, perdeu_d, timeout_d;
  logic [3:0] db_d;

  // Rising edge of the button level: a held button yields one press.
  assign press   = jogada & ~jogada_q;
  assign tmo_hit = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:     if (iniciar) state_d = PREPARA;
      PREPARA:     state_d = ESPERA;
      ESPERA: begin
        if (press)        state_d = REGISTRA;
        else if (tmo_hit) state_d = FIM_TIMEOUT;
      end
      REGISTRA:    state_d = COMPARA;
      COMPARA: begin
        if (!igual)    state_d = FIM_ERRO;
        else if (fimC) state_d = FIM_ACERTO;
        else           state_d = PROXIMO;
      end
      PROXIMO:     state_d = ESPERA;
      FIM_ACERTO,
      FIM_TIMEOUT,
      FIM_ERRO:    if (iniciar) state_d = PREPARA;
      default:     state_d = INICIAL;
    endcase
  end

  // Timer runs only while staying in ESPERA; entry always sees zero.
  always_comb begin
    timer_d = '0;
    if (state_q == ESPERA && state_d == ESPERA)
      timer_d = timer_q + TW'(1);
  end

  // Outputs decoded from the next state and registered, so they
  // line up exactly with the state register.
  always_comb begin
    zeraC_d     = 1'b0;
    contaC_d    = 1'b0;
    zeraR_d     = 1'b0;
    registraR_d = 1'b0;
    pronto_d    = 1'b0;
    ganhou_d    = 1'b0;
    perdeu_d    = 1'b0;
    timeout_d   = 1'b0;
    db_d        = 4'hF;
    case (state_d)
      INICIAL, PREPARA: begin
        zeraC_d = 1'b1;
        zeraR_d = 1'b1;
        db_d    = state_d;
      end
      ESPERA:   db_d = state_d;
      REGISTRA: begin
        registraR_d = 1'b1;
        db_d        = state_d;
      end
      COMPARA:  db_d = state_d;
      PROXIMO: begin
        contaC_d = 1'b1;
        db_d     = state_d;
      end
      FIM_ACERTO: begin
        pronto_d = 1'b1;
        ganhou_d = 1'b1;
        db_d     = state_d;
      end
      FIM_TIMEOUT: begin
        pronto_d  = 1'b1;
        timeout_d = 1'b1;
        db_d      = state_d;
      end
      FIM_ERRO: begin
        pronto_d = 1'b1;
        perdeu_d = 1'b1;
        db_d     = state_d;
      end
      default: db_d = 4'hF;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= INICIAL;
      timer_q   <= '0;
      jogada_q  <= 1'b0;
      zeraC     <= 1'b1;
      contaC    <= 1'b0;
      zeraR     <= 1'b1;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      ganhou    <= 1'b0;
      perdeu    <= 1'b0;
      timeout   <= 1'b0;
      db_estado <= 4'h0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      jogada_q  <= jogada;
      zeraC     <= zeraC_d;
      contaC    <= contaC_d;
      zeraR     <= zeraR_d;
      registraR <= registraR_d;
      pronto    <= pronto_d;
      ganhou    <= ganhou_d;
      perdeu    <= perdeu_d;
      timeout   <= timeout_d;
      db_estado <= db_d;
    end
  end

endmodule

// File: tb/tb_exp5_unidade_controle_jogada.sv
// Bench for the play control unit: vector table for win/loss
// rounds, hand sequences for timeout, boundary, held button, reset.
module tb_exp5_unidade_controle_jogada;

  logic       clock, reset;
  logic       iniciar, jogada, fimC, igual;
  logic       zeraC, contaC, zeraR, registraR;
  logic       pronto, ganhou, perdeu, timeout;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;
  int n_conta = 0;
  int n_reg = 0;

  exp5_unidade_controle_jogada #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .iniciar(iniciar), .jogada(jogada),
    .fimC(fimC), .igual(igual),
    .zeraC(zeraC), .contaC(contaC),
    .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .ganhou(ganhou),
    .perdeu(perdeu), .timeout(timeout),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       ini;
    logic       jog;
    logic       fim;
    logic       igu;
    logic [3:0] est;
  } vec_t;

  vec_t vt[$];

  // Expected output bundle for a state code:
  // {zeraC,contaC,zeraR,registraR,pronto,ganhou,perdeu,timeout}
  function automatic logic [7:0] dec(input logic [3:0] s);
    case (s)
      4'h0, 4'h1: dec = 8'b1010_0000;
      4'h4:       dec = 8'b0001_0000;
      4'h6:       dec = 8'b0100_0000;
      4'hA:       dec = 8'b0000_1100;
      4'hB:       dec = 8'b0000_1001;
      4'hE:       dec = 8'b0000_1010;
      default:    dec = 8'b0000_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_st(input string nm, input logic [3:0] s);
    chk({nm, "_st"}, 16'(db_estado), 16'(s));
    chk({nm, "_out"},
        16'({zeraC, contaC, zeraR, registraR,
             pronto, ganhou, perdeu, timeout}),
        16'(dec(s)));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (contaC) n_conta++;
    if (registraR) n_reg++;
  endtask

  task automatic drive(input logic i, input logic j,
                       input logic f, input logic g);
    iniciar = i;
    jogada  = j;
    fimC    = f;
    igual   = g;
  endtask

  task automatic run_rows(input string nm, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      drive(vt[k].ini, vt[k].jog, vt[k].fim, vt[k].igu);
      tick();
      chk_st($sformatf("%s_r%0d", nm, k - lo), vt[k].est);
    end
  endtask

  task automatic add(input logic i, input logic j, input logic f,
                     input logic g, input logic [3:0] e);
    vec_t v;
    v.ini = i; v.jog = j; v.fim = f; v.igu = g; v.est = e;
    vt.push_back(v);
  endtask

  initial begin
    // Win: rows 0..17
    add(1, 0, 0, 1, 4'h1);
    add(0, 0, 0, 1, 4'h2);
    for (int r = 0; r < 3; r++) begin
      add(0, 1, 0, 1, 4'h4);
      add(0, 0, 0, 1, 4'h5);
      add(0, 0, 0, 1, 4'h6);
      add(0, 0, 0, 1, 4'h2);
    end
    add(0, 1, 0, 1, 4'h4);
    add(0, 0, 1, 1, 4'h5);
    add(0, 0, 1, 1, 4'hA);
    add(0, 0, 0, 1, 4'hA);
    // Loss: rows 18..27
    add(1, 0, 0, 1, 4'h1);
    add(0, 0, 0, 1, 4'h2);
    add(0, 1, 0, 1, 4'h4);
    add(0, 0, 0, 1, 4'h5);
    add(0, 0, 0, 1, 4'h6);
    add(0, 0, 0, 1, 4'h2);
    add(0, 1, 0, 1, 4'h4);
    add(0, 0, 0, 0, 4'h5);
    add(0, 0, 0, 0, 4'hE);
    add(0, 0, 0, 0, 4'hE);

    reset = 1'b1;
    drive(0, 0, 0, 0);
    #12;
    chk_st("reset", 4'h0);
    reset = 1'b0;
    tick();
    chk_st("idle", 4'h0);

    n_conta = 0;
    run_rows("win", 0, 17);
    chk("win_conta", 16'(n_conta), 16'd3);

    n_conta = 0;
    run_rows("loss", 18, 27);
    chk("loss_conta", 16'(n_conta), 16'd1);

    // Timeout: exactly 8 cycles in ESPERA
    drive(1, 0, 0, 1); tick(); chk_st("to_prep", 4'h1);
    drive(0, 0, 0, 1); tick(); chk_st("to_esp0", 4'h2);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk_st($sformatf("to_esp%0d", k), 4'h2);
    end
    tick(); chk_st("to_fim", 4'hB);
    tick(); chk_st("to_hold", 4'hB);

    // Boundary: press in the 8th ESPERA cycle wins over timeout
    drive(1, 0, 0, 1); tick(); chk_st("bd_prep", 4'h1);
    drive(0, 0, 0, 1); tick(); chk_st("bd_esp0", 4'h2);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk_st($sformatf("bd_esp%0d", k), 4'h2);
    end
    drive(0, 1, 0, 1); tick(); chk_st("bd_reg", 4'h4);
    drive(0, 0, 0, 0); tick(); chk_st("bd_cmp", 4'h5);
    tick(); chk_st("bd_err", 4'hE);

    // Held button: one registraR, next ESPERA times out
    drive(1, 0, 0, 1); tick(); chk_st("hd_prep", 4'h1);
    drive(0, 0, 0, 1); tick(); chk_st("hd_esp", 4'h2);
    n_reg = 0;
    drive(0, 1, 0, 1); tick(); chk_st("hd_reg", 4'h4);
    tick(); chk_st("hd_cmp", 4'h5);
    tick(); chk_st("hd_prox", 4'h6);
    tick(); chk_st("hd_esp0", 4'h2);
    for (int k = 1; k < 8; k++) tick();
    chk_st("hd_esp7", 4'h2);
    tick(); chk_st("hd_to", 4'hB);
    for (int k = 0; k < 8; k++) tick();
    chk_st("hd_hold", 4'hB);
    chk("hd_nreg", 16'(n_reg), 16'd1);
    drive(0, 0, 0, 1);

    // Async reset while in COMPARA, between clock edges
    drive(1, 0, 0, 1); tick(); chk_st("rs_prep", 4'h1);
    drive(0, 0, 0, 1); tick(); chk_st("rs_esp", 4'h2);
    drive(0, 1, 0, 1); tick(); chk_st("rs_reg", 4'h4);
    drive(0, 0, 0, 1); tick(); chk_st("rs_cmp", 4'h5);
    #2 reset = 1'b1;
    #1 chk_st("rs_async", 4'h0);
    #1 reset = 1'b0;
    tick(); chk_st("rs_idle", 4'h0);
    drive(1, 0, 0, 1); tick(); chk_st("rs_prep2", 4'h1);
    drive(0, 0, 0, 1); tick(); chk_st("rs_esp2", 4'h2);
    drive(0, 1, 0, 1); tick(); chk_st("rs_reg2", 4'h4);
    drive(0, 0, 1, 1); tick(); chk_st("rs_cmp2", 4'h5);
    tick(); chk_st("rs_win", 4'hA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
